riscv_cpu: RTL and testbench

RISCV_CPU -- requirements
Module: riscv_cpu

---
 rtl/riscv_cpu_pkg.sv | 114 +++++++++++
 rtl/riscv_regfile.sv | 36 +++
 rtl/riscv_cpu.sv | 164 ++++++++++++++++
 tb/tb_riscv_cpu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cpu_pkg
// Description : Shared opcodes, control struct, pipeline buses and decode
//               helpers for the riscv_cpu 5-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_cpu_pkg;

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_WORD = 3'b010;
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_JALR = 3'b000;
    localparam logic [6:0] c_F7_ADD  = 7'b0000000;
    localparam logic [6:0] c_F7_SUB  = 7'b0100000;

    localparam logic [31:0] c_NOP = 32'h00000013;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic jalr;
        logic sub;
        logic use_imm;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] wb_data;
    } memwb_t;

    localparam ifid_t  c_IFID_BUBBLE  = '{pc: 32'd0, instr: c_NOP};
    localparam idex_t  c_IDEX_BUBBLE  = '0;
    localparam exmem_t c_EXMEM_BUBBLE = '0;
    localparam memwb_t c_MEMWB_BUBBLE = '0;

    // Anything outside the supported subset decodes to all-zero control (a NOP).
    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        c = '0;
        case (ins[6:0])
            c_OPC_LOAD: if (ins[14:12] == c_F3_WORD) begin
                c.reg_write = 1'b1; c.mem_read = 1'b1; c.use_imm = 1'b1;
            end
            c_OPC_STORE: if (ins[14:12] == c_F3_WORD) begin
                c.mem_write = 1'b1; c.use_imm = 1'b1;
            end
            c_OPC_OP: if (ins[14:12] == c_F3_ADD &&
                          (ins[31:25] == c_F7_ADD || ins[31:25] == c_F7_SUB)) begin
                c.reg_write = 1'b1; c.sub = ins[30];
            end
            c_OPC_OPIMM: if (ins[14:12] == c_F3_ADD) begin
                c.reg_write = 1'b1; c.use_imm = 1'b1;
            end
            c_OPC_BRANCH: if (ins[14:12] == c_F3_BEQ) c.branch = 1'b1;
            c_OPC_JAL: begin
                c.reg_write = 1'b1; c.jump = 1'b1;
            end
            c_OPC_JALR: if (ins[14:12] == c_F3_JALR) begin
                c.reg_write = 1'b1; c.jump = 1'b1; c.jalr = 1'b1; c.use_imm = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] ins);
        case (ins[6:0])
            c_OPC_STORE:  return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            c_OPC_BRANCH: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            c_OPC_JAL:    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:      return {{20{ins[31]}}, ins[31:20]};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_regfile.sv
`default_nettype none
// ============================================================================
// Module      : riscv_regfile
// Description : 32x32 register file, x0 hardwired to zero, WB write bypassed
//               to same-cycle reads.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] Regs [0:31];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) Regs[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            Regs[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0)                ? 32'd0 :
                   (we_i && wa_i == ra1_i)        ? wd_i  : Regs[ra1_i];
    assign rd2_o = (ra2_i == 5'd0)                ? 32'd0 :
                   (we_i && wa_i == ra2_i)        ? wd_i  : Regs[ra2_i];

endmodule
`default_nettype wire

// File: rtl/riscv_cpu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_cpu
// Description : 5-stage RV32I subset pipeline (lw/sw/add/sub/addi/beq/jal/jalr).
//               Define RISCV_CPU_FORWARD_EN for forwarding + 1-cycle load-use
//               stall; otherwise ID stalls until source writers reach WB.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_cpu
    import riscv_cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic clock,
    input logic reset
);

    localparam int c_IAW = $clog2(IMEM_WORDS);
    localparam int c_DAW = $clog2(DMEM_WORDS);
`ifdef RISCV_CPU_FORWARD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    ifid_t  ifid_q,  ifid_d;
    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic [31:0] pc_d;

    logic [31:0] w_pc, w_instr, w_rf_rd1, w_rf_rd2, w_imm;
    ctrl_t       w_id_ctrl;
    logic        w_use_rs1, w_use_rs2, w_stall, w_flush;
    logic [4:0]  w_id_rs1, w_id_rs2;
    logic [31:0] w_op_a, w_op_b, w_alu_b, w_alu, w_target, w_dmem_rdata;

    // ---------------- IF ----------------
    if (1) begin : if_stage
        logic [31:0] PC;
        always_ff @(posedge clock) begin
            if (reset) PC <= '0;
            else       PC <= pc_d;
        end
    end
    assign w_pc = if_stage.PC;

    if (1) begin : imem
        logic [31:0] IMem [0:IMEM_WORDS-1];
    end
    assign w_instr = imem.IMem[w_pc[c_IAW+1:2]];

    // ---------------- ID ----------------
    assign w_id_ctrl = decode(ifid_q.instr);
    assign w_imm     = imm_gen(ifid_q.instr);
    assign w_use_rs1 = w_id_ctrl.mem_read | w_id_ctrl.mem_write | w_id_ctrl.branch |
                       w_id_ctrl.jalr | (w_id_ctrl.reg_write & ~w_id_ctrl.jump);
    assign w_use_rs2 = w_id_ctrl.mem_write | w_id_ctrl.branch |
                       (w_id_ctrl.reg_write & ~w_id_ctrl.use_imm & ~w_id_ctrl.jump);
    assign w_id_rs1  = w_use_rs1 ? ifid_q.instr[19:15] : 5'd0;
    assign w_id_rs2  = w_use_rs2 ? ifid_q.instr[24:20] : 5'd0;

    riscv_regfile regfile (
        .clk_i (clock),
        .rst_i (reset),
        .ra1_i (w_id_rs1),
        .ra2_i (w_id_rs2),
        .we_i  (memwb_q.reg_write),
        .wa_i  (memwb_q.rd),
        .wd_i  (memwb_q.wb_data),
        .rd1_o (w_rf_rd1),
        .rd2_o (w_rf_rd2)
    );

    // Non-writers carry rd=0, so a nonzero rd match always means a real hazard.
`ifdef RISCV_CPU_FORWARD_EN
    assign w_stall = idex_q.ctrl.mem_read && idex_q.rd != 5'd0 &&
                     (idex_q.rd == w_id_rs1 || idex_q.rd == w_id_rs2);
`else
    assign w_stall = (idex_q.rd != 5'd0 && (idex_q.rd == w_id_rs1 || idex_q.rd == w_id_rs2)) ||
                     (exmem_q.rd != 5'd0 && (exmem_q.rd == w_id_rs1 || exmem_q.rd == w_id_rs2));
`endif

    // ---------------- EX ----------------
    always_comb begin
        w_op_a = idex_q.rs1_val;
        w_op_b = idex_q.rs2_val;
        if (c_FWD && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1)      w_op_a = exmem_q.result;
        else if (c_FWD && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) w_op_a = memwb_q.wb_data;
        if (c_FWD && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2)      w_op_b = exmem_q.result;
        else if (c_FWD && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) w_op_b = memwb_q.wb_data;
    end

    assign w_alu_b  = idex_q.ctrl.use_imm ? idex_q.imm : w_op_b;
    assign w_alu    = idex_q.ctrl.sub ? (w_op_a - w_alu_b) : (w_op_a + w_alu_b);
    assign w_flush  = idex_q.ctrl.jump | (idex_q.ctrl.branch & (w_op_a == w_op_b));
    assign w_target = idex_q.ctrl.jalr ? (w_alu & ~32'd1) : (idex_q.pc + idex_q.imm);

    always_comb begin
        exmem_d.reg_write  = idex_q.ctrl.reg_write;
        exmem_d.mem_read   = idex_q.ctrl.mem_read;
        exmem_d.mem_write  = idex_q.ctrl.mem_write;
        exmem_d.result     = idex_q.ctrl.jump ? (idex_q.pc + 32'd4) : w_alu;
        exmem_d.store_data = w_op_b;
        exmem_d.rd         = idex_q.rd;
    end

    // ---------------- MEM ----------------
    if (1) begin : dmem
        logic [31:0] DMem [0:DMEM_WORDS-1];
        always_ff @(posedge clock) begin
            if (!reset && exmem_q.mem_write)
                DMem[exmem_q.result[c_DAW+1:2]] <= exmem_q.store_data;
        end
    end
    assign w_dmem_rdata = dmem.DMem[exmem_q.result[c_DAW+1:2]];

    always_comb begin
        memwb_d.reg_write = exmem_q.reg_write;
        memwb_d.rd        = exmem_q.rd;
        memwb_d.wb_data   = exmem_q.mem_read ? w_dmem_rdata : exmem_q.result;
    end

    // ---------------- front-end sequencing: flush beats stall ----------------
    always_comb begin
        pc_d           = w_pc + 32'd4;
        ifid_d.pc      = w_pc;
        ifid_d.instr   = w_instr;
        idex_d.ctrl    = w_id_ctrl;
        idex_d.pc      = ifid_q.pc;
        idex_d.rs1_val = w_rf_rd1;
        idex_d.rs2_val = w_rf_rd2;
        idex_d.imm     = w_imm;
        idex_d.rs1     = w_id_rs1;
        idex_d.rs2     = w_id_rs2;
        idex_d.rd      = w_id_ctrl.reg_write ? ifid_q.instr[11:7] : 5'd0;
        if (w_flush) begin
            pc_d   = w_target;
            ifid_d = c_IFID_BUBBLE;
            idex_d = c_IDEX_BUBBLE;
        end else if (w_stall) begin
            pc_d   = w_pc;
            ifid_d = ifid_q;
            idex_d = c_IDEX_BUBBLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ifid_q  <= c_IFID_BUBBLE;
            idex_q  <= c_IDEX_BUBBLE;
            exmem_q <= c_EXMEM_BUBBLE;
            memwb_q <= c_MEMWB_BUBBLE;
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_cpu
// Description : Directed self-checking bench for riscv_cpu (program table,
//               mid-run reset, load-use stall cycle count).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_cpu;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    riscv_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clock (clock),
        .reset (reset)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [20];
    logic [31:0] prog [25];

    function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, opc);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic load_imem(input int n);
        for (int i = 0; i < 256; i++) dut.imem.IMem[i] = 32'h00000013;
        for (int i = 0; i < n; i++)   dut.imem.IMem[i] = prog[i];
    endtask

    int          holds;
    logic [31:0] prev_pc;

    initial begin
        // Program A: load-use, store/load, taken/not-taken beq, jalr, jal, priority, unsupported op
        prog[0]  = enc_i(0,    0, 2, 1,  32'h03);      // lw   x1,0(x0)
        prog[1]  = enc_i(10,   0, 0, 2,  32'h13);      // addi x2,x0,10
        prog[2]  = enc_r(0,    2, 1, 0, 3);            // add  x3,x1,x2
        prog[3]  = enc_r(32,   1, 3, 0, 4);            // sub  x4,x3,x1
        prog[4]  = enc_s(4,    4, 0);                  // sw   x4,4(x0)
        prog[5]  = enc_i(4,    0, 2, 5,  32'h03);      // lw   x5,4(x0)
        prog[6]  = enc_b(8,    2, 5);                  // beq  x5,x2,+8 (taken)
        prog[7]  = enc_i(999,  0, 0, 6,  32'h13);      // addi x6,x0,999 (flushed)
        prog[8]  = enc_b(8,    0, 2);                  // beq  x2,x0,+8 (not taken)
        prog[9]  = enc_i(77,   0, 0, 10, 32'h13);      // addi x10,x0,77
        prog[10] = enc_i(64,   0, 0, 7,  32'h13);      // addi x7,x0,64
        prog[11] = enc_i(1,   10, 0, 11, 32'h13);      // addi x11,x10,1
        prog[12] = enc_i(0,    7, 0, 8,  32'h67);      // jalr x8,0(x7)
        prog[13] = 32'h00000013;
        prog[14] = 32'h00000013;
        prog[15] = 32'h00000013;
        prog[16] = enc_i(1234, 0, 0, 9,  32'h13);      // addi x9,x0,1234
        prog[17] = enc_s(8,    9, 0);                  // sw   x9,8(x0)
        prog[18] = enc_j(8,    12);                    // jal  x12,+8
        prog[19] = enc_i(1,    0, 0, 13, 32'h13);      // addi x13,x0,1 (flushed)
        prog[20] = enc_i(1,    0, 0, 16, 32'h13);      // addi x16,x0,1
        prog[21] = enc_i(2,    0, 0, 16, 32'h13);      // addi x16,x0,2
        prog[22] = enc_r(0,   16, 16, 0, 17);          // add  x17,x16,x16
        prog[23] = enc_r(0,    2, 1, 6, 15);           // or   x15,x1,x2 (unsupported)
        prog[24] = enc_j(0,    0);                     // jal  x0,0 (halt loop)

        vecs[0]  = '{1'b0, 0,  32'd0};
        vecs[1]  = '{1'b0, 1,  32'd5};
        vecs[2]  = '{1'b0, 2,  32'd10};
        vecs[3]  = '{1'b0, 3,  32'd15};
        vecs[4]  = '{1'b0, 4,  32'd10};
        vecs[5]  = '{1'b0, 5,  32'd10};
        vecs[6]  = '{1'b0, 6,  32'd0};
        vecs[7]  = '{1'b0, 7,  32'd64};
        vecs[8]  = '{1'b0, 8,  32'd52};
        vecs[9]  = '{1'b0, 9,  32'd1234};
        vecs[10] = '{1'b0, 10, 32'd77};
        vecs[11] = '{1'b0, 11, 32'd78};
        vecs[12] = '{1'b0, 12, 32'd76};
        vecs[13] = '{1'b0, 13, 32'd0};
        vecs[14] = '{1'b0, 15, 32'd0};
        vecs[15] = '{1'b0, 16, 32'd2};
        vecs[16] = '{1'b0, 17, 32'd4};
        vecs[17] = '{1'b1, 0,  32'd5};
        vecs[18] = '{1'b1, 1,  32'd10};
        vecs[19] = '{1'b1, 2,  32'd1234};

        reset = 1'b1;
        load_imem(25);
        for (int i = 0; i < 256; i++) dut.dmem.DMem[i] <= 32'd0;
        #1;
        dut.dmem.DMem[0] <= 32'd5;
        tick(3);
        check("reset PC", dut.if_stage.PC, 32'd0);
        check("reset IF/ID instr", dut.ifid_q.instr, 32'h00000013);
        check("reset x5", dut.regfile.Regs[5], 32'd0);

        // Partial run, then reset mid-program
        reset = 1'b0;
        tick(10);
        check("x1 before mid-run reset", dut.regfile.Regs[1], 32'd5);
        reset = 1'b1;
        tick(2);
        check("mid-reset PC", dut.if_stage.PC, 32'd0);
        check("mid-reset x1 cleared", dut.regfile.Regs[1], 32'd0);
        check("mid-reset IF/ID bubble", dut.ifid_q.instr, 32'h00000013);
        check("mid-reset EX/MEM no store", 32'(dut.exmem_q.mem_write), 32'd0);
        check("mid-reset MEM/WB no write", 32'(dut.memwb_q.reg_write), 32'd0);
        check("mid-reset DMem[0] kept", dut.dmem.DMem[0], 32'd5);
        reset = 1'b0;
        tick(1);
        check("restart PC", dut.if_stage.PC, 32'd4);
        check("restart IF/ID instr", dut.ifid_q.instr, prog[0]);

        tick(300);
        for (int k = 0; k < 20; k++) begin
            if (vecs[k].is_mem)
                check($sformatf("DMem[%0d]", vecs[k].idx), dut.dmem.DMem[vecs[k].idx], vecs[k].exp);
            else
                check($sformatf("x%0d", vecs[k].idx), dut.regfile.Regs[vecs[k].idx], vecs[k].exp);
        end

        // Program B: back-to-back load-use, count cycles in which PC is held
        reset = 1'b1;
        prog[0] = enc_i(0, 0, 2, 1, 32'h03);           // lw  x1,0(x0)
        prog[1] = enc_r(0, 1, 1, 0, 3);                // add x3,x1,x1
        prog[2] = enc_j(0, 0);                         // jal x0,0
        load_imem(3);
        tick(2);
        reset   = 1'b0;
        holds   = 0;
        prev_pc = dut.if_stage.PC;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (dut.if_stage.PC == prev_pc) holds++;
            prev_pc = dut.if_stage.PC;
        end
`ifdef RISCV_CPU_FORWARD_EN
        check("load-use stall cycles", holds, 32'd1);
`else
        check("load-use stall cycles", holds, 32'd2);
`endif
        check("load-use x3", dut.regfile.Regs[3], 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
